// File: rtl/mem_access_unit.sv
// mem_access_unit: one-outstanding load/store stage driving a single-word AXI master port.
// Optional MAU_MISALIGN_TRAP_EN: misaligned half/word accesses fail without touching the bus.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  output logic [31:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [2:0]  dbg_state
);
  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // a valid, once raised, holds with stable payload until that edge, then drops.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_AR = 3'd1, S_R = 3'd2, S_AWW = 3'd3,
    S_B = 3'd4, S_ERR = 3'd5, S_RESP = 3'd6
  } state_t;

  localparam int unsigned WDW = $clog2(TIMEOUT + 2);

  state_t      state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        arvalid_q, arvalid_d, rready_q, rready_d;
  logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic [31:0] araddr_q, araddr_d, awaddr_q, awaddr_d, wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic [1:0]  lo_q, lo_d, size_q, size_d;
  logic        sgn_q, sgn_d;
  logic [WDW-1:0] wd_q, wd_d, wd_inc;
  logic        wait_st, timeout_hit, misalign;
  logic        unused_resp_lsb;

  assign unused_resp_lsb = ^{m_axi_rresp[0], m_axi_bresp[0]};

  function automatic logic [31:0] load_extend(input logic [31:0] d, input logic [1:0] lo,
                                              input logic [1:0] sz, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{lo, 3'b000} +: 8];
    h = d[{lo[1], 4'b0000} +: 16];
    case (sz)
      2'd0:    load_extend = {{24{sgn & b[7]}}, b};
      2'd1:    load_extend = {{16{sgn & h[15]}}, h};
      default: load_extend = d;
    endcase
  endfunction

  always_comb begin
`ifdef MAU_MISALIGN_TRAP_EN
    misalign = (req_size == 2'd1 && req_addr[0]) || (req_size == 2'd2 && req_addr[1:0] != 2'b00);
`else
    misalign = 1'b0;
`endif
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    araddr_d     = araddr_q;
    awaddr_d     = awaddr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    lo_d         = lo_q;
    size_d       = size_q;
    sgn_d        = sgn_q;
    wait_st      = (state_q == S_AR) || (state_q == S_R) || (state_q == S_AWW) || (state_q == S_B);
    wd_inc       = wd_q + WDW'(1);
    timeout_hit  = (TIMEOUT != 0) && wait_st && (wd_inc == WDW'(TIMEOUT));

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          req_ready_d = 1'b0;
          lo_d        = req_addr[1:0];
          size_d      = req_size;
          sgn_d       = req_signed;
          araddr_d    = {req_addr[31:2], 2'b00};
          awaddr_d    = {req_addr[31:2], 2'b00};
          if (req_size == 2'd3 || misalign) begin
            state_d = S_ERR;
          end else if (req_we) begin
            state_d   = S_AWW;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            case (req_size)
              2'd0:    begin wdata_d = {4{req_wdata[7:0]}};  wstrb_d = 4'b0001 << req_addr[1:0]; end
              2'd1:    begin wdata_d = {2{req_wdata[15:0]}}; wstrb_d = 4'b0011 << {req_addr[1], 1'b0}; end
              default: begin wdata_d = req_wdata;            wstrb_d = 4'b1111; end
            endcase
          end else begin
            state_d   = S_AR;
            arvalid_d = 1'b1;
          end
        end
      end
      S_AR: if (m_axi_arready) begin
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
        state_d   = S_R;
      end
      S_R: if (m_axi_rvalid) begin
        rready_d     = 1'b0;
        resp_valid_d = 1'b1;
        resp_rdata_d = load_extend(m_axi_rdata, lo_q, size_q, sgn_q);
        resp_err_d   = m_axi_rresp[1];
        state_d      = S_RESP;
      end
      S_AWW: begin
        awvalid_d = awvalid_q && !m_axi_awready;
        wvalid_d  = wvalid_q && !m_axi_wready;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = S_B;
        end
      end
      S_B: if (m_axi_bvalid) begin
        bready_d     = 1'b0;
        resp_valid_d = 1'b1;
        resp_rdata_d = 32'h0;
        resp_err_d   = m_axi_bresp[1];
        state_d      = S_RESP;
      end
      S_ERR: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = 32'h0;
        resp_err_d   = 1'b1;
        state_d      = S_RESP;
      end
      S_RESP: begin
        resp_rdata_d = 32'h0;
        resp_err_d   = 1'b0;
        req_ready_d  = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Watchdog abort is terminal for the bus: every handshake signal is withdrawn.
    if (timeout_hit) begin
      arvalid_d    = 1'b0;
      rready_d     = 1'b0;
      awvalid_d    = 1'b0;
      wvalid_d     = 1'b0;
      bready_d     = 1'b0;
      resp_valid_d = 1'b1;
      resp_rdata_d = 32'h0;
      resp_err_d   = 1'b1;
      state_d      = S_RESP;
    end

    wd_d = (TIMEOUT != 0 && wait_st && state_d == state_q) ? wd_inc : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      araddr_q     <= 32'h0;
      awaddr_q     <= 32'h0;
      wdata_q      <= 32'h0;
      wstrb_q      <= 4'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      lo_q         <= 2'b00;
      size_q       <= 2'b00;
      sgn_q        <= 1'b0;
      wd_q         <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      araddr_q     <= araddr_d;
      awaddr_q     <= awaddr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      lo_q         <= lo_d;
      size_q       <= size_d;
      sgn_q        <= sgn_d;
      wd_q         <= wd_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign resp_err      = resp_err_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign dbg_state     = state_q;
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- CPU-side load/store stage that drives the single-word AXI master port (m_axi_*) of the 2-way set-associative cache controller.
- Accepts one load/store at a time with size and sign information.
- Generates aligned AXI address, replicated write data and byte strobes; extracts and sign/zero-extends load data; reports bus errors.
- One outstanding transaction; responses are returned in order.

Parameters:
- TIMEOUT, 1023: cycles allowed in any bus-wait state before the watchdog aborts; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit idle, request accepted when valid&&ready
- req_we  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word, 3=illegal
- req_signed  in  1  load sign-extends when 1
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  error flag, valid with resp_valid
- m_axi_araddr  out 32; m_axi_arvalid out 1; m_axi_arready in 1
- m_axi_rdata in 32; m_axi_rresp in 2; m_axi_rvalid in 1; m_axi_rready out 1
- m_axi_awaddr out 32; m_axi_awvalid out 1; m_axi_awready in 1
- m_axi_wdata out 32; m_axi_wstrb out 4; m_axi_wvalid out 1; m_axi_wready in 1
- m_axi_bresp in 2; m_axi_bvalid in 1; m_axi_bready out 1

Behaviour:
- Reset: state=IDLE. All valid/ready outputs 0 except req_ready=1. resp_* = 0, addr/data/strb outputs = 0, watchdog = 0.
- Reset mid-transaction abandons the transaction immediately; no response is issued.
- All outputs are registered.
- IDLE: req_ready=1. On accept, latch the request, drop req_ready, decode:
  - size 3 → RESP with err.
  - load → AR.
  - store → AWW.
- Address: m_axi_araddr and m_axi_awaddr = {addr[31:2],2'b00}.
- AR: m_axi_arvalid=1 from the cycle after accept; hold until arready. On handshake, arvalid←0, rready←1, go to R.
- R: on rvalid, rready←0, select the lane:
  - byte = rdata[8*addr[1:0] +: 8]
  - half = rdata[16*addr[1] +: 16]
  - word = rdata
  - Extend per req_signed (word unaffected). err = rresp[1]. Go to RESP.
- AWW: awvalid and wvalid both rise the cycle after accept. Each drops independently on its own ready. Either order and simultaneous acceptance are legal.
  - wdata: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
  - wstrb: byte 4'b0001<<addr[1:0], half 4'b0011<<{addr[1],1'b0}, word 4'b1111.
  - When both are accepted, bready←1, go to B.
- B: on bvalid, bready←0, err = bresp[1], go to RESP.
- RESP: resp_valid=1 for exactly one cycle with rdata/err, then IDLE; req_ready=1 in the following cycle.
- Minimum load latency (ready slave): accept → arvalid +1 → rready +2 → resp_valid on the cycle after rvalid is sampled.
- Watchdog: counts cycles in AR/R/AWW/B and resets on every state change. At count==TIMEOUT (TIMEOUT≠0), all m_axi valid/ready outputs go to 0 and the unit enters RESP with err=1. This condition is fatal; the bus is not expected to recover.
- Half access with addr[0]=1 (without the optional feature): addr[0] is ignored for lane selection. Word access ignores addr[1:0].

Optional Feature:
- Macro: MAU_MISALIGN_TRAP_EN.
- Defined: a half access with addr[0]≠0, or a word access with addr[1:0]≠0, skips the bus entirely and goes to RESP with err=1, rdata=0. Latency is 2 cycles from accept to resp_valid.
- Undefined: the access is performed with the low bits truncated as described under Behaviour.

Test Plan:
- Signed byte load: addr 0x103, rdata 0x80AABBCC, rresp 0 → araddr 0x100, resp_rdata 0xFFFFFF80, err 0. Same access unsigned → 0x00000080.
- Half store: addr 0x202, wdata 0x00001234 → awaddr 0x200, wdata 0x12341234, wstrb 4'b1100, resp_valid after bvalid, err 0.
- Handshake ordering: wready 3 cycles before awready, then awready 5 cycles before wready. Each valid drops only on its own ready; bready asserts only after both; exactly one resp_valid.
- Error responses: bresp 2'b10 on a word store and rresp 2'b11 on a load → resp_err=1, load resp_rdata reflects the extended data.
- Robustness: TIMEOUT=8 with arready held 0 → resp_err=1 at the 8th wait cycle, arvalid 0 afterwards. rst asserted while in B → outputs return to reset values asynchronously, no resp_valid.
- MAU_MISALIGN_TRAP_EN defined, word load at 0x1 → no arvalid, resp_valid 2 cycles after accept, err 1.
